// File: rtl/keychain_cmd_sequencer_if.sv
// Bundles the byte-level UART handshake and the cipher-core handshake seen by
// keychain_cmd_sequencer. The sequencer connects through the slave modport; the
// surrounding logic (UART, cipher core) uses the master modport.
interface keychain_cmd_sequencer_if #(
  parameter int KEY_BYTES = 4,
  parameter int MSG_BYTES = 2
);
  logic                   rx_valid_in;
  logic [7:0]             rx_data_in;
  logic [7:0]             tx_data_out;
  logic                   tx_valid_out;
  logic                   tx_ready_in;
  logic [KEY_BYTES*8-1:0] key_out;
  logic                   key_valid_out;
  logic [MSG_BYTES*8-1:0] msg_out;
  logic                   msg_valid_out;
  logic                   core_ready_in;
  logic [MSG_BYTES*8-1:0] result_in;
  logic                   result_valid_in;
  logic                   busy_out;

  modport slave (
    input  rx_valid_in, rx_data_in, tx_ready_in, core_ready_in, result_in, result_valid_in,
    output tx_data_out, tx_valid_out, key_out, key_valid_out, msg_out, msg_valid_out, busy_out
  );

  modport master (
    output rx_valid_in, rx_data_in, tx_ready_in, core_ready_in, result_in, result_valid_in,
    input  tx_data_out, tx_valid_out, key_out, key_valid_out, msg_out, msg_valid_out, busy_out
  );
endinterface

// File: rtl/keychain_cmd_sequencer.sv
// keychain_cmd_sequencer: parses framed host commands ('K' key load, 'E' encrypt,
// 'S' status), loads the key register, hands messages to the cipher core and
// streams results back out over the UART TX handshake. Payloads are big-endian.
// Optional build macro KEYCHAIN_SEQ_ACK_EN: ACK 0x06 after a key load and NAK 0x3F
// after a timeout abort; without it both cases are silent.
module keychain_cmd_sequencer #(
  parameter int KEY_BYTES      = 4,
  parameter int MSG_BYTES      = 2,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input logic                     clk_in,
  input logic                     rst_n_in,
  keychain_cmd_sequencer_if.slave bus
);
  localparam int KEY_W     = KEY_BYTES * 8;
  localparam int MSG_W     = MSG_BYTES * 8;
  localparam int MAX_BYTES = (KEY_BYTES > MSG_BYTES) ? KEY_BYTES : MSG_BYTES;
  localparam int SHIFT_W   = MAX_BYTES * 8;
  localparam int CNT_W     = $clog2(MAX_BYTES + 1);
  localparam int TMO_W     = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] OP_KEY  = 8'h4B;
  localparam logic [7:0] OP_ENC  = 8'h45;
  localparam logic [7:0] OP_STAT = 8'h53;
  localparam logic [7:0] NAK     = 8'h3F;
  localparam logic [7:0] ACK     = 8'h06;

  typedef enum logic [2:0] {IDLE, RX_KEY, RX_MSG, ISSUE, WAIT_RES, TX_RES, TX_ONE} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [SHIFT_W-1:0] shift_reg, shift_next, shift_in;
  logic [KEY_W-1:0]   key_reg, key_next;
  logic               key_valid_reg, key_valid_next;
  logic [MSG_W-1:0]   msg_reg, msg_next;
  logic [MSG_W-1:0]   result_reg, result_next;
  logic [7:0]         tx_byte_reg, tx_byte_next;
  logic               is_status_reg, is_status_next;
  logic               key_loaded_reg, key_loaded_next;
  logic               err_reg, err_next;
  logic               overrun_reg, overrun_next;
  logic [TMO_W-1:0]   tmo_reg, tmo_next;
  logic               tx_fire, tmo_last;

  // Received byte shifted in at the LSB end so the first byte lands in the MSBs.
  generate
    if (SHIFT_W > 8) begin : g_shift_wide
      assign shift_in = {shift_reg[SHIFT_W-9:0], bus.rx_data_in};
    end else begin : g_shift_byte
      assign shift_in = bus.rx_data_in;
    end
  endgenerate

  assign tx_fire  = bus.tx_valid_out && bus.tx_ready_in;
  // True when one more idle cycle would reach the timeout limit.
  assign tmo_last = (tmo_reg >= TMO_W'(TIMEOUT_CYCLES - 1));

  // State and datapath registers; reset also wipes the key.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      shift_reg      <= '0;
      key_reg        <= '0;
      key_valid_reg  <= 1'b0;
      msg_reg        <= '0;
      result_reg     <= '0;
      tx_byte_reg    <= '0;
      is_status_reg  <= 1'b0;
      key_loaded_reg <= 1'b0;
      err_reg        <= 1'b0;
      overrun_reg    <= 1'b0;
      tmo_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      shift_reg      <= shift_next;
      key_reg        <= key_next;
      key_valid_reg  <= key_valid_next;
      msg_reg        <= msg_next;
      result_reg     <= result_next;
      tx_byte_reg    <= tx_byte_next;
      is_status_reg  <= is_status_next;
      key_loaded_reg <= key_loaded_next;
      err_reg        <= err_next;
      overrun_reg    <= overrun_next;
      tmo_reg        <= tmo_next;
    end
  end

  // Command parsing, transfer sequencing, timeout abort and flag bookkeeping.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    shift_next      = shift_reg;
    key_next        = key_reg;
    key_valid_next  = 1'b0;
    msg_next        = msg_reg;
    result_next     = result_reg;
    tx_byte_next    = tx_byte_reg;
    is_status_next  = is_status_reg;
    key_loaded_next = key_loaded_reg;
    err_next        = err_reg;
    overrun_next    = overrun_reg;
    tmo_next        = (tmo_reg == TMO_W'(TIMEOUT_CYCLES)) ? tmo_reg : tmo_reg + TMO_W'(1);

    case (state_reg)
      IDLE: begin
        tmo_next = '0;
        if (bus.rx_valid_in) begin
          case (bus.rx_data_in)
            OP_KEY: begin
              state_next = RX_KEY;
              cnt_next   = CNT_W'(KEY_BYTES);
            end
            OP_ENC: begin
              state_next = RX_MSG;
              cnt_next   = CNT_W'(MSG_BYTES);
            end
            OP_STAT: begin
              state_next     = TX_ONE;
              tx_byte_next   = {5'b0, overrun_reg, err_reg, key_loaded_reg};
              is_status_next = 1'b1;
            end
            default: begin
              state_next     = TX_ONE;
              tx_byte_next   = NAK;
              is_status_next = 1'b0;
              err_next       = 1'b1;
            end
          endcase
        end
      end
      RX_KEY, RX_MSG: begin
        if (bus.rx_valid_in) begin
          shift_next = shift_in;
          tmo_next   = '0;
          cnt_next   = cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) begin
            if (state_reg == RX_KEY) begin
              key_next        = shift_in[KEY_W-1:0];
              key_valid_next  = 1'b1;
              key_loaded_next = 1'b1;
`ifdef KEYCHAIN_SEQ_ACK_EN
              state_next      = TX_ONE;
              tx_byte_next    = ACK;
              is_status_next  = 1'b0;
`else
              state_next      = IDLE;
`endif
            end else if (key_loaded_reg) begin
              msg_next   = shift_in[MSG_W-1:0];
              state_next = ISSUE;
            end else begin
              state_next     = TX_ONE;
              tx_byte_next   = NAK;
              is_status_next = 1'b0;
              err_next       = 1'b1;
            end
          end
        end else if (tmo_last) begin
          err_next = 1'b1;
`ifdef KEYCHAIN_SEQ_ACK_EN
          state_next     = TX_ONE;
          tx_byte_next   = NAK;
          is_status_next = 1'b0;
`else
          state_next     = IDLE;
`endif
        end
      end
      ISSUE: begin
        if (bus.core_ready_in) begin
          state_next = WAIT_RES;
          tmo_next   = '0;
        end
      end
      WAIT_RES: begin
        if (bus.result_valid_in) begin
          result_next = bus.result_in;
          cnt_next    = CNT_W'(MSG_BYTES);
          state_next  = TX_RES;
        end else if (tmo_last) begin
          err_next = 1'b1;
`ifdef KEYCHAIN_SEQ_ACK_EN
          state_next     = TX_ONE;
          tx_byte_next   = NAK;
          is_status_next = 1'b0;
`else
          state_next     = IDLE;
`endif
        end
      end
      TX_RES: begin
        if (tx_fire) begin
          result_next = result_reg << 8;
          cnt_next    = cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) state_next = IDLE;
        end
      end
      TX_ONE: begin
        if (tx_fire) begin
          state_next = IDLE;
          // Only the flags the status byte actually reported are cleared.
          if (is_status_reg) begin
            err_next     = err_reg & ~tx_byte_reg[1];
            overrun_next = overrun_reg & ~tx_byte_reg[2];
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Bytes arriving while busy sending or waiting on the core are lost.
    if (bus.rx_valid_in && (state_reg == ISSUE || state_reg == WAIT_RES ||
                            state_reg == TX_RES || state_reg == TX_ONE)) begin
      overrun_next = 1'b1;
    end
  end

  assign bus.tx_valid_out  = (state_reg == TX_RES) || (state_reg == TX_ONE);
  assign bus.tx_data_out   = (state_reg == TX_RES) ? result_reg[MSG_W-1 -: 8] :
                             (state_reg == TX_ONE) ? tx_byte_reg : 8'h00;
  assign bus.key_out       = key_reg;
  assign bus.key_valid_out = key_valid_reg;
  assign bus.msg_out       = msg_reg;
  assign bus.msg_valid_out = (state_reg == ISSUE);
  assign bus.busy_out      = (state_reg != IDLE);
endmodule

// File: tb/tb_keychain_cmd_sequencer.sv
// Scoreboard bench for keychain_cmd_sequencer: stimulus pushes expected tx bytes,
// key loads and core messages into queues; a monitor pops and compares whenever
// the DUT presents one. A small core model answers issued messages.
module tb_keychain_cmd_sequencer;
  logic clk_10mhz = 1'b0;
  logic rst_n     = 1'b0;

  always #50 clk_10mhz = ~clk_10mhz;

  keychain_cmd_sequencer_if #(.KEY_BYTES(4), .MSG_BYTES(2)) bus ();

  keychain_cmd_sequencer #(.KEY_BYTES(4), .MSG_BYTES(2), .TIMEOUT_CYCLES(100)) dut (
    .clk_in   (clk_10mhz),
    .rst_n_in (rst_n),
    .bus      (bus)
  );

  int n_vec  = 0;
  int n_fail = 0;
  int core_delay = 3;

  logic [7:0]  exp_tx_q[$];
  logic [31:0] exp_key_q[$];
  logic [15:0] exp_msg_q[$];
  logic [15:0] core_resp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk_10mhz); #1;
    bus.rx_valid_in = 1'b1;
    bus.rx_data_in  = b;
    @(posedge clk_10mhz); #1;
    bus.rx_valid_in = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(posedge clk_10mhz); #1;
    while (bus.busy_out && n < 500) begin
      @(posedge clk_10mhz); #1;
      n++;
    end
    if (n >= 500) check({name, " idle timeout"}, 32'(bus.busy_out), 32'd0);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, " tx_valid"},  32'(bus.tx_valid_out),  32'd0);
    check({name, " tx_data"},   32'(bus.tx_data_out),   32'd0);
    check({name, " key_out"},   bus.key_out,            32'd0);
    check({name, " key_valid"}, 32'(bus.key_valid_out), 32'd0);
    check({name, " msg_out"},   32'(bus.msg_out),       32'd0);
    check({name, " msg_valid"}, 32'(bus.msg_valid_out), 32'd0);
    check({name, " busy"},      32'(bus.busy_out),      32'd0);
  endtask

  // Monitor: compares every DUT-presented transfer against the scoreboard.
  initial begin
    forever begin
      @(negedge clk_10mhz);
      if (rst_n && bus.tx_valid_out && bus.tx_ready_in) begin
        if (exp_tx_q.size() == 0) check("unexpected tx byte", 32'(bus.tx_data_out), 32'hFFFF_FFFF);
        else check("tx byte", 32'(bus.tx_data_out), 32'(exp_tx_q.pop_front()));
      end
      if (rst_n && bus.key_valid_out) begin
        if (exp_key_q.size() == 0) check("unexpected key_valid", bus.key_out, 32'hFFFF_FFFF);
        else check("key load", bus.key_out, exp_key_q.pop_front());
      end
      if (rst_n && bus.msg_valid_out && bus.core_ready_in) begin
        if (exp_msg_q.size() == 0) check("unexpected msg issue", 32'(bus.msg_out), 32'hFFFF_FFFF);
        else check("msg issue", 32'(bus.msg_out), 32'(exp_msg_q.pop_front()));
      end
    end
  end

  // Core model: answers each accepted message after core_delay cycles.
  initial begin
    logic [15:0] r;
    forever begin
      @(negedge clk_10mhz);
      if (rst_n && bus.msg_valid_out && bus.core_ready_in && core_resp_q.size() > 0) begin
        r = core_resp_q.pop_front();
        repeat (core_delay) @(posedge clk_10mhz);
        #1;
        bus.result_valid_in = 1'b1;
        bus.result_in       = r;
        @(posedge clk_10mhz); #1;
        bus.result_valid_in = 1'b0;
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] held;
    int changes;
    int n;

    bus.rx_valid_in     = 1'b0;
    bus.rx_data_in      = 8'h00;
    bus.tx_ready_in     = 1'b1;
    bus.core_ready_in   = 1'b1;
    bus.result_in       = 16'h0000;
    bus.result_valid_in = 1'b0;

    // Reset state
    repeat (3) @(posedge clk_10mhz);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // Encrypt without a key: NAK, then status shows err, then clears
    exp_tx_q.push_back(8'h3F);
    send_byte(8'h45); send_byte(8'hAB); send_byte(8'hCD);
    wait_idle("nokey");
    exp_tx_q.push_back(8'h02);
    send_byte(8'h53);
    wait_idle("status1");
    exp_tx_q.push_back(8'h00);
    send_byte(8'h53);
    wait_idle("status2");

    // Key load
    exp_key_q.push_back(32'h0123_4567);
`ifdef KEYCHAIN_SEQ_ACK_EN
    exp_tx_q.push_back(8'h06);
`endif
    send_byte(8'h4B); send_byte(8'h01); send_byte(8'h23); send_byte(8'h45); send_byte(8'h67);
    wait_idle("keyload");
    check("key_out after load", bus.key_out, 32'h0123_4567);
    check("busy after load", 32'(bus.busy_out), 32'd0);

    // Encrypt
    exp_msg_q.push_back(16'hABCD);
    core_resp_q.push_back(16'h1234);
    exp_tx_q.push_back(8'h12);
    exp_tx_q.push_back(8'h34);
    send_byte(8'h45); send_byte(8'hAB); send_byte(8'hCD);
    wait_idle("encrypt");

    // Backpressure during result transmission
    bus.tx_ready_in = 1'b0;
    exp_msg_q.push_back(16'h0FF0);
    core_resp_q.push_back(16'hBEEF);
    exp_tx_q.push_back(8'hBE);
    exp_tx_q.push_back(8'hEF);
    send_byte(8'h45); send_byte(8'h0F); send_byte(8'hF0);
    n = 0;
    while (!bus.tx_valid_out && n < 200) begin
      @(posedge clk_10mhz); #1;
      n++;
    end
    check("bp tx_valid seen", 32'(bus.tx_valid_out), 32'd1);
    held = bus.tx_data_out;
    changes = 0;
    repeat (50) begin
      @(posedge clk_10mhz); #1;
      if (bus.tx_data_out !== held || !bus.tx_valid_out) changes++;
    end
    check("bp held byte", 32'(held), 32'h0000_00BE);
    check("bp stable cycles", 32'(changes), 32'd0);
    bus.tx_ready_in = 1'b1;
    wait_idle("backpressure");
    check("bp tx queue drained", 32'(exp_tx_q.size()), 32'd0);

    // Overrun: byte arriving during WAIT_RES is dropped
    core_delay = 20;
    exp_msg_q.push_back(16'h1122);
    core_resp_q.push_back(16'h3344);
    exp_tx_q.push_back(8'h33);
    exp_tx_q.push_back(8'h44);
    send_byte(8'h45); send_byte(8'h11); send_byte(8'h22);
    repeat (2) @(posedge clk_10mhz);
    send_byte(8'h99);
    wait_idle("overrun");
    core_delay = 3;
    exp_tx_q.push_back(8'h05);
    send_byte(8'h53);
    wait_idle("status overrun");
    exp_tx_q.push_back(8'h01);
    send_byte(8'h53);
    wait_idle("status cleared");

    // Unknown opcode
    exp_tx_q.push_back(8'h3F);
    send_byte(8'h77);
    wait_idle("badop");
    exp_tx_q.push_back(8'h03);
    send_byte(8'h53);
    wait_idle("status badop");

    // Timeout mid key load: key unchanged, err set
    send_byte(8'h4B); send_byte(8'h01);
    repeat (100) @(posedge clk_10mhz);
    #1;
`ifdef KEYCHAIN_SEQ_ACK_EN
    exp_tx_q.push_back(8'h3F);
    wait_idle("timeout nak");
`else
    check("timeout back to idle", 32'(bus.busy_out), 32'd0);
`endif
    check("key_out after timeout", bus.key_out, 32'h0123_4567);
    exp_tx_q.push_back(8'h03);
    send_byte(8'h53);
    wait_idle("status timeout");

    // Reset in the middle of a key load
    send_byte(8'h4B); send_byte(8'hAA); send_byte(8'hBB);
    #2;
    rst_n = 1'b0;
    #2;
    check_outputs_zero("midreset");
    @(posedge clk_10mhz); #1;
    rst_n = 1'b1;
    exp_tx_q.push_back(8'h00);
    send_byte(8'h53);
    wait_idle("status after reset");

    repeat (5) @(posedge clk_10mhz);
    check("tx queue empty",   32'(exp_tx_q.size()),  32'd0);
    check("key queue empty",  32'(exp_key_q.size()), 32'd0);
    check("msg queue empty",  32'(exp_msg_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
